// File: rtl/accel_sequencer_if.sv
// Command/response channel between the accelerometer sequencer and the SPI master.
// The sequencer presents one command at a time with a valid/ready handshake and
// receives MISO bytes plus an end-of-transaction pulse.
interface accel_sequencer_if;
    logic       txn_valid;
    logic       txn_ready;
    logic [7:0] txn_cmd;
    logic [7:0] txn_wdata;
    logic [1:0] txn_wr_len;
    logic [2:0] txn_rd_len;
    logic [7:0] rd_byte;
    logic       rd_byte_valid;
    logic       txn_done;

    modport master (
        output txn_valid, txn_cmd, txn_wdata, txn_wr_len, txn_rd_len,
        input  txn_ready, rd_byte, rd_byte_valid, txn_done
    );

    modport slave (
        input  txn_valid, txn_cmd, txn_wdata, txn_wr_len, txn_rd_len,
        output txn_ready, rd_byte, rd_byte_valid, txn_done
    );
endinterface

// File: rtl/accel_sequencer.sv
// Accelerometer sequencer: writes DATA_FORMAT, BW_RATE and POWER_CTL over an SPI
// master, then performs six-byte X/Y/Z burst reads on request. Every wait for the
// SPI master is guarded by a cycle timeout that parks the block in ERR.
module accel_sequencer #(
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h04,
    parameter logic [7:0]  BW_RATE_VAL     = 8'h0F,
    parameter logic [7:0]  POWER_CTL_VAL   = 8'h08,
    parameter logic [15:0] TIMEOUT_CYC     = 16'd4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sample_tick,
    accel_sequencer_if.master        txn,
    output logic [15:0]              x_data,
    output logic [15:0]              y_data,
    output logic [15:0]              z_data,
    output logic                     sample_valid,
    output logic                     init_done,
    output logic                     busy,
    output logic                     txn_err,
    output logic [7:0]               drop_count
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_FMT_ISSUE  = 4'd1;
    localparam logic [3:0] ST_FMT_WAIT   = 4'd2;
    localparam logic [3:0] ST_RATE_ISSUE = 4'd3;
    localparam logic [3:0] ST_RATE_WAIT  = 4'd4;
    localparam logic [3:0] ST_PWR_ISSUE  = 4'd5;
    localparam logic [3:0] ST_PWR_WAIT   = 4'd6;
    localparam logic [3:0] ST_READY      = 4'd7;
    localparam logic [3:0] ST_AX_ISSUE   = 4'd8;
    localparam logic [3:0] ST_AX_WAIT    = 4'd9;
    localparam logic [3:0] ST_ERR        = 4'd10;

    localparam logic [2:0] AX_BYTES = 3'd6;

    logic [3:0]  state_q, state_d;
    logic        init_done_q, init_done_d;
    logic        txn_err_q, txn_err_d;
    logic        sample_valid_q, sample_valid_d;
    logic [7:0]  drop_q, drop_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [7:0]  cap_q [0:5];
    logic [7:0]  cap_d [0:5];

    logic       handshake;
    logic       in_wait;
    logic       byte_take;
    logic [2:0] byte_cnt_eff;

    // Command fields are a pure decode of the ISSUE state, so they stay stable until the handshake.
    always_comb begin
        txn.txn_valid  = 1'b0;
        txn.txn_cmd    = 8'h00;
        txn.txn_wdata  = 8'h00;
        txn.txn_wr_len = 2'd0;
        txn.txn_rd_len = 3'd0;
        case (state_q)
            ST_FMT_ISSUE: begin
                txn.txn_valid  = 1'b1;
                txn.txn_cmd    = 8'h31;
                txn.txn_wdata  = DATA_FORMAT_VAL;
                txn.txn_wr_len = 2'd2;
            end
            ST_RATE_ISSUE: begin
                txn.txn_valid  = 1'b1;
                txn.txn_cmd    = 8'h2C;
                txn.txn_wdata  = BW_RATE_VAL;
                txn.txn_wr_len = 2'd2;
            end
            ST_PWR_ISSUE: begin
                txn.txn_valid  = 1'b1;
                txn.txn_cmd    = 8'h2D;
                txn.txn_wdata  = POWER_CTL_VAL;
                txn.txn_wr_len = 2'd2;
            end
            ST_AX_ISSUE: begin
                txn.txn_valid  = 1'b1;
                txn.txn_cmd    = 8'hF2;
                txn.txn_wr_len = 2'd1;
                txn.txn_rd_len = AX_BYTES;
            end
            default: ;
        endcase
    end

    assign handshake    = txn.txn_valid && txn.txn_ready;
    assign in_wait      = (state_q == ST_FMT_WAIT) || (state_q == ST_RATE_WAIT) ||
                          (state_q == ST_PWR_WAIT) || (state_q == ST_AX_WAIT);
    assign byte_take    = (state_q == ST_AX_WAIT) && txn.rd_byte_valid && (byte_cnt_q < AX_BYTES);
    // A byte arriving with txn_done counts toward completeness of this read.
    assign byte_cnt_eff = byte_cnt_q + {2'b00, byte_take};

    // Next-state, capture and status logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        init_done_d    = init_done_q;
        txn_err_d      = txn_err_q;
        sample_valid_d = 1'b0;
        drop_d         = drop_q;
        byte_cnt_d     = byte_cnt_q;
        tmo_d          = tmo_q;
        x_d            = x_q;
        y_d            = y_q;
        z_d            = z_q;
        cap_d          = cap_q;

        if (byte_take) begin
            cap_d[byte_cnt_q] = txn.rd_byte;
        end

        // Ticks that arrive after configuration but while a read is outstanding are lost.
        if (sample_tick && init_done_q && (state_q != ST_READY) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            ST_IDLE, ST_ERR, ST_READY: begin
                if (start) begin
                    state_d     = ST_FMT_ISSUE;
                    init_done_d = 1'b0;
                    txn_err_d   = 1'b0;
                end else if ((state_q == ST_READY) && sample_tick) begin
                    state_d = ST_AX_ISSUE;
                end
            end
            ST_FMT_ISSUE:  if (handshake) begin state_d = ST_FMT_WAIT;  tmo_d = 16'd0; end
            ST_RATE_ISSUE: if (handshake) begin state_d = ST_RATE_WAIT; tmo_d = 16'd0; end
            ST_PWR_ISSUE:  if (handshake) begin state_d = ST_PWR_WAIT;  tmo_d = 16'd0; end
            ST_AX_ISSUE: begin
                if (handshake) begin
                    state_d    = ST_AX_WAIT;
                    tmo_d      = 16'd0;
                    byte_cnt_d = 3'd0;
                end
            end
            ST_FMT_WAIT:  if (txn.txn_done) state_d = ST_RATE_ISSUE;
            ST_RATE_WAIT: if (txn.txn_done) state_d = ST_PWR_ISSUE;
            ST_PWR_WAIT: begin
                if (txn.txn_done) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_AX_WAIT: begin
                byte_cnt_d = byte_cnt_eff;
                if (txn.txn_done) begin
                    state_d = ST_READY;
                    if (byte_cnt_eff == AX_BYTES) begin
                        x_d            = {cap_d[1], cap_d[0]};
                        y_d            = {cap_d[3], cap_d[2]};
                        z_d            = {cap_d[5], cap_d[4]};
                        sample_valid_d = 1'b1;
                    end else begin
                        txn_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared watchdog for all WAIT states; overrides the per-state hold.
        if (in_wait && !txn.txn_done) begin
            if (tmo_q == TIMEOUT_CYC - 16'd1) begin
                state_d     = ST_ERR;
                txn_err_d   = 1'b1;
                init_done_d = 1'b0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            init_done_q    <= 1'b0;
            txn_err_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            drop_q         <= 8'd0;
            byte_cnt_q     <= 3'd0;
            tmo_q          <= 16'd0;
            x_q            <= 16'd0;
            y_q            <= 16'd0;
            z_q            <= 16'd0;
        end else begin
            state_q        <= state_d;
            init_done_q    <= init_done_d;
            txn_err_q      <= txn_err_d;
            sample_valid_q <= sample_valid_d;
            drop_q         <= drop_d;
            byte_cnt_q     <= byte_cnt_d;
            tmo_q          <= tmo_d;
            x_q            <= x_d;
            y_q            <= y_d;
            z_q            <= z_d;
        end
    end

    // Raw MISO byte capture buffer.
    always_ff @(posedge clk) begin
        // NOTE: the capture buffer is not reset; it only reaches x/y/z after six fresh bytes are written.
        cap_q <= cap_d;
    end

    assign x_data       = x_q;
    assign y_data       = y_q;
    assign z_data       = z_q;
    assign sample_valid = sample_valid_q;
    assign init_done    = init_done_q;
    assign txn_err      = txn_err_q;
    assign drop_count   = drop_q;
    assign busy         = !((state_q == ST_IDLE) || (state_q == ST_READY) || (state_q == ST_ERR));

endmodule
